gcd_operand_loader: RTL

Front-end stage that feeds the GCD core. It debounces the active-low ENTER pushbutton and assembles two operands from successive 4-bit switch nibbles, MSB nibble first. It presents the completed operand pair to the core with a valid/ready handshake. The core consumes `op_a`/`op_b` on the handshake and starts its subtraction loop.

---
 rtl/gcd_operand_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gcd_operand_loader.sv
// gcd_operand_loader: front end for the GCD core.
// Synchronizes and debounces the active-low ENTER key. Builds two operands from
// successive 4-bit SW nibbles, MSB nibble first, and offers the pair over a
// valid/ready handshake.
// Optional feature: define GCD_LOADER_ABS_EN so that negative (MSB set) operands
// are replaced by their two's-complement magnitude when the pair is offered.
module gcd_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned OPERAND_W       = 8,
    localparam int unsigned IdxW           = $clog2(OPERAND_W / 2)
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 KEY_ENTER,
    input  logic [3:0]           SW,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [IdxW-1:0]      nibble_idx
);

    localparam int unsigned NumNib = OPERAND_W / 2;
    localparam int unsigned PairW  = 2 * OPERAND_W;
    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

    typedef enum logic {
        StEntry,
        StOffer
    } state_e;

    // ------------------------------------------------------------------
    // Key synchronizer and debouncer
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      fill_q, fill_d;
    logic            armed_q, armed_d;
    logic            press_q, press_d;

    // Two-flop synchronizer; both stages come out of reset as "released".
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= KEY_ENTER;
            sync2_q <= sync1_q;
        end
    end

    // Debounce counter, press arming and press pulse next-state.
    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        armed_d = armed_q;

        if (sync2_q != db_q) begin
            if (cnt_q == CntMax) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end

        // fill_q counts edges since reset until sync2_q holds a real pin sample;
        // the reset value of the synchronizer must not be mistaken for a release.
        if (fill_q != 2'd2) begin
            fill_d = fill_q + 2'd1;
        end

        // A key held through reset must be seen released before it can press.
        if (fill_q == 2'd2 && sync2_q && db_q) begin
            armed_d = 1'b1;
        end

        press_d = armed_q & db_q & ~db_d;
    end

    // Debounce and press-pulse state.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            db_q    <= 1'b1;
            cnt_q   <= '0;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand assembly and handshake
    // ------------------------------------------------------------------
    state_e               state_q;
    logic [OPERAND_W-1:0] op_a_q, op_b_q;
    logic                 valid_q;
    logic [IdxW-1:0]      idx_q;

    logic [PairW-1:0]     pair_wr;
    logic [OPERAND_W-1:0] a_wr, b_wr;
    logic [OPERAND_W-1:0] a_fin, b_fin;

    // Operand pair with the current SW nibble written at nibble_idx; nibble 0 is
    // the MSB nibble of op_a, the last nibble is the LSB nibble of op_b.
    always_comb begin
        pair_wr = {op_a_q, op_b_q};
        for (int i = 0; i < int'(NumNib); i++) begin
            if (idx_q == IdxW'(i)) begin
                pair_wr[PairW - 4 - 4 * i +: 4] = SW;
            end
        end
        a_wr = pair_wr[PairW-1:OPERAND_W];
        b_wr = pair_wr[OPERAND_W-1:0];
    end

    // Values latched on the way into OFFER.
    always_comb begin
`ifdef GCD_LOADER_ABS_EN
        a_fin = a_wr[OPERAND_W-1] ? (~a_wr + OPERAND_W'(1)) : a_wr;
        b_fin = b_wr[OPERAND_W-1] ? (~b_wr + OPERAND_W'(1)) : b_wr;
`else
        a_fin = a_wr;
        b_fin = b_wr;
`endif
    end

    // Entry/offer FSM; all outputs are registered here.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= StEntry;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StEntry: begin
                    if (press_q) begin
                        if (idx_q == LastIdx) begin
                            op_a_q  <= a_fin;
                            op_b_q  <= b_fin;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                            state_q <= StOffer;
                        end else begin
                            op_a_q <= a_wr;
                            op_b_q <= b_wr;
                            idx_q  <= idx_q + IdxW'(1);
                        end
                    end
                end
                StOffer: begin
                    // Presses here are dropped; operands stay frozen.
                    if (valid_q && op_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StEntry;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StEntry;
                end
            endcase
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = valid_q;
    assign nibble_idx = idx_q;

endmodule
